// File: rtl/remove_pkt.sv
// remove_pkt: round-robin output-queue reader that streams one packet (header + body) from SRAM to the output FIFO.
// Optional length reporting is enabled with the REMOVE_PKT_LEN_REPORT_EN macro.
module remove_pkt #(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH/8,
    parameter int NUM_OUTPUT_QUEUES = 5,
    parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
    parameter int SRAM_ADDR_WIDTH   = 19,
    parameter int PKT_WORDS_WIDTH   = 8,
    parameter int MAX_OUTSTANDING   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_OUTPUT_QUEUES-1:0]     src_oq_empty,
    output logic                             rd_src_addr,
    output logic [NUM_OQ_WIDTH-1:0]          src_oq,
    input  logic [SRAM_ADDR_WIDTH-1:0]       src_oq_rd_addr,
    input  logic [SRAM_ADDR_WIDTH-1:0]       src_oq_low_addr,
    input  logic [SRAM_ADDR_WIDTH-1:0]       src_oq_high_addr,
    output logic [SRAM_ADDR_WIDTH-1:0]       src_oq_rd_addr_new,
    output logic                             pkt_removed,
    output logic                             rd_0_req,
    output logic [SRAM_ADDR_WIDTH-1:0]       rd_0_addr,
    input  logic                             rd_0_ack,
    input  logic                             rd_0_vld,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] rd_0_data,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
`ifdef REMOVE_PKT_LEN_REPORT_EN
    output logic [PKT_WORDS_WIDTH-1:0]       removed_pkt_word_len,
    output logic [15:0]                      removed_pkt_byte_len,
`endif
    input  logic                             out_almost_full
);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {IDLE, READ_ADDR, LATCH_ADDR, READ_HDR, WAIT_HDR, READ_BODY, DRAIN} state_t;

    state_t                         state_q, state_d;
    logic [NUM_OQ_WIDTH-1:0]        rr_q, rr_d, src_oq_q, src_oq_d, sel_idx, up_idx, dn_idx;
    logic                           sel_found, up_hit, dn_hit;
    logic                           rd_src_addr_q, rd_src_addr_d, req_q, req_d, pkt_removed_q, pkt_removed_d;
    logic [SRAM_ADDR_WIDTH-1:0]     lo_q, lo_d, hi_q, hi_d, addr_q, addr_d, new_ptr_q, new_ptr_d;
    logic [PKT_WORDS_WIDTH-1:0]     rem_q, rem_d, hdr_n;
    logic [OW-1:0]                  outst_q, outst_d;
    logic                           ack_ok, vld_ok, issue_ok;
    logic                           out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]          out_ctrl_q, out_ctrl_d;

    function automatic logic [SRAM_ADDR_WIDTH-1:0] wrap(input logic [SRAM_ADDR_WIDTH-1:0] a);
        return (a >= hi_q) ? lo_q : a + 1'b1;
    endfunction

    assign ack_ok   = req_q && rd_0_ack;
    assign vld_ok   = rd_0_vld && (outst_q != '0);
    assign outst_d  = outst_q + OW'(ack_ok) - OW'(vld_ok);
    assign issue_ok = (outst_d < MAX_O) && !out_almost_full;
    assign hdr_n    = rd_0_data[48 +: PKT_WORDS_WIDTH];

    // round-robin pick: lowest non-empty index above the pointer, else lowest at or below it
    always_comb begin
        up_hit = 1'b0;
        dn_hit = 1'b0;
        up_idx = '0;
        dn_idx = '0;
        for (int k = NUM_OUTPUT_QUEUES-1; k >= 0; k--) begin
            if (!src_oq_empty[k] && k > int'(rr_q)) begin
                up_hit = 1'b1;
                up_idx = NUM_OQ_WIDTH'(k);
            end
            if (!src_oq_empty[k] && k <= int'(rr_q)) begin
                dn_hit = 1'b1;
                dn_idx = NUM_OQ_WIDTH'(k);
            end
        end
        sel_found = up_hit || dn_hit;
        sel_idx   = up_hit ? up_idx : dn_idx;
    end

    // packet sequencing: queue selection, header fetch, body streaming, drain
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        src_oq_d      = src_oq_q;
        rd_src_addr_d = 1'b0;
        lo_d          = lo_q;
        hi_d          = hi_q;
        addr_d        = addr_q;
        req_d         = req_q;
        rem_d         = rem_q;
        pkt_removed_d = 1'b0;
        new_ptr_d     = new_ptr_q;
        out_wr_d      = vld_ok;
        out_data_d    = rd_0_vld ? rd_0_data[DATA_WIDTH-1:0] : out_data_q;
        out_ctrl_d    = rd_0_vld ? rd_0_data[DATA_WIDTH +: CTRL_WIDTH] : out_ctrl_q;
        case (state_q)
            IDLE: if (sel_found) begin
                src_oq_d      = sel_idx;
                rr_d          = sel_idx;
                rd_src_addr_d = 1'b1;
                state_d       = READ_ADDR;
            end
            READ_ADDR: state_d = LATCH_ADDR;
            LATCH_ADDR: begin
                lo_d    = src_oq_low_addr;
                hi_d    = src_oq_high_addr;
                addr_d  = src_oq_rd_addr;
                req_d   = 1'b1;
                state_d = READ_HDR;
            end
            READ_HDR: if (ack_ok) begin
                req_d   = 1'b0;
                state_d = WAIT_HDR;
            end
            WAIT_HDR: if (vld_ok) begin
                if (hdr_n == '0) state_d = DRAIN;
                else begin
                    addr_d  = wrap(addr_q);
                    rem_d   = hdr_n;
                    req_d   = issue_ok;
                    state_d = READ_BODY;
                end
            end
            READ_BODY: begin
                if (ack_ok && rem_q == PKT_WORDS_WIDTH'(1)) begin
                    req_d   = 1'b0;
                    state_d = DRAIN;
                end else if (ack_ok) begin
                    rem_d  = rem_q - 1'b1;
                    addr_d = wrap(addr_q);
                    req_d  = issue_ok;
                end else if (!req_q) req_d = issue_ok;
            end
            DRAIN: if (outst_q == '0) begin
                pkt_removed_d = 1'b1;
                new_ptr_d     = wrap(addr_q);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_q          <= NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES-1);
            src_oq_q      <= '0;
            rd_src_addr_q <= 1'b0;
            lo_q          <= '0;
            hi_q          <= '0;
            addr_q        <= '0;
            req_q         <= 1'b0;
            rem_q         <= '0;
            outst_q       <= '0;
            pkt_removed_q <= 1'b0;
            new_ptr_q     <= '0;
            out_wr_q      <= 1'b0;
            out_data_q    <= '0;
            out_ctrl_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            src_oq_q      <= src_oq_d;
            rd_src_addr_q <= rd_src_addr_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            addr_q        <= addr_d;
            req_q         <= req_d;
            rem_q         <= rem_d;
            outst_q       <= outst_d;
            pkt_removed_q <= pkt_removed_d;
            new_ptr_q     <= new_ptr_d;
            out_wr_q      <= out_wr_d;
            out_data_q    <= out_data_d;
            out_ctrl_q    <= out_ctrl_d;
        end
    end

    assign rd_src_addr        = rd_src_addr_q;
    assign src_oq             = src_oq_q;
    assign src_oq_rd_addr_new = new_ptr_q;
    assign pkt_removed        = pkt_removed_q;
    assign rd_0_req           = req_q;
    assign rd_0_addr          = addr_q;
    assign out_wr             = out_wr_q;
    assign out_data           = out_data_q;
    assign out_ctrl           = out_ctrl_q;

`ifdef REMOVE_PKT_LEN_REPORT_EN
    logic [PKT_WORDS_WIDTH-1:0] n_q, n_d, word_len_q, word_len_d;
    logic [15:0]                bytes_q, bytes_d, byte_len_q, byte_len_d;

    // capture header length fields, publish them together with pkt_removed
    always_comb begin
        n_d        = (state_q == WAIT_HDR && vld_ok) ? hdr_n : n_q;
        bytes_d    = (state_q == WAIT_HDR && vld_ok) ? rd_0_data[15:0] : bytes_q;
        word_len_d = pkt_removed_d ? n_q + 1'b1 : word_len_q;
        byte_len_d = pkt_removed_d ? bytes_q : byte_len_q;
    end

    // length report registers
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q        <= '0;
            bytes_q    <= '0;
            word_len_q <= '0;
            byte_len_q <= '0;
        end else begin
            n_q        <= n_d;
            bytes_q    <= bytes_d;
            word_len_q <= word_len_d;
            byte_len_q <= byte_len_d;
        end
    end

    assign removed_pkt_word_len = word_len_q;
    assign removed_pkt_byte_len = byte_len_q;
`endif
endmodule

// File: tb/tb_remove_pkt.sv
// tb_remove_pkt: table-driven and scoreboard bench for remove_pkt with a register-block and SRAM model.
module tb_remove_pkt;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  src_oq_empty;
    logic        rd_src_addr;
    logic [2:0]  src_oq;
    logic [18:0] src_oq_rd_addr, src_oq_low_addr, src_oq_high_addr, src_oq_rd_addr_new;
    logic        pkt_removed, rd_0_req;
    logic [18:0] rd_0_addr;
    logic        rd_0_ack, rd_0_vld;
    logic [71:0] rd_0_data;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr, out_almost_full;

    remove_pkt dut (
        .clk(clk), .reset(reset), .src_oq_empty(src_oq_empty), .rd_src_addr(rd_src_addr),
        .src_oq(src_oq), .src_oq_rd_addr(src_oq_rd_addr), .src_oq_low_addr(src_oq_low_addr),
        .src_oq_high_addr(src_oq_high_addr), .src_oq_rd_addr_new(src_oq_rd_addr_new),
        .pkt_removed(pkt_removed), .rd_0_req(rd_0_req), .rd_0_addr(rd_0_addr), .rd_0_ack(rd_0_ack),
        .rd_0_vld(rd_0_vld), .rd_0_data(rd_0_data), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_wr(out_wr), .out_almost_full(out_almost_full)
    );

    always #5 clk = ~clk;

    typedef struct {int q; logic [18:0] rd, lo, hi; logic [7:0] n; logic [18:0] new_ptr;} vec_t;
    typedef struct {int due; logic [18:0] a;} rd_t;
    typedef struct {int q; logic [18:0] ptr;} rm_t;

    int          n_checks = 0, n_fail = 0, cyc = 0, ack_cnt = 0;
    logic        ack_rand = 1'b1, af_prev = 1'b0;
    logic [71:0] mem [int];
    logic [71:0] exp_words [$];
    rm_t         exp_rm [$];
    rd_t         pend [$];
    logic [18:0] q_rd [8], q_lo [8], q_hi [8], tail [8];
    int          q_cnt [8];
    vec_t        vecs [6];

    task automatic check(string name, logic [71:0] act, logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] nxt(logic [18:0] a, logic [18:0] lo, logic [18:0] hi);
        return (a >= hi) ? lo : a + 19'd1;
    endfunction

    function automatic logic [71:0] mem_word(logic [18:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : {8'h00, 13'h1A5A, 32'hC0FFEE00, a};
    endfunction

    task automatic set_q(int q, logic [18:0] rd, logic [18:0] lo, logic [18:0] hi);
        q_rd[q] = rd;
        tail[q] = rd;
        q_lo[q] = lo;
        q_hi[q] = hi;
    endtask

    // place a packet at the queue tail and queue its expected words and removal record
    task automatic add_pkt(int q, logic [7:0] n, logic [18:0] exp_new);
        logic [18:0] a;
        a = tail[q];
        mem[int'(a)] = {8'hFF, 8'h00, n, 32'h0, 8'h00, n + 8'd1};
        exp_words.push_back(mem[int'(a)]);
        for (int i = 0; i < int'(n); i++) begin
            a = nxt(a, q_lo[q], q_hi[q]);
            exp_words.push_back(mem_word(a));
        end
        tail[q] = nxt(a, q_lo[q], q_hi[q]);
        exp_rm.push_back('{q, exp_new});
        q_cnt[q]++;
    endtask

    // negedge: score outputs, then drive register-block and SRAM responses for the next edge
    task automatic model_step();
        rd_t p;
        rm_t r;
        cyc++;
        if (out_wr) begin
            if (exp_words.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_wr: got word %0h, expected no write", {out_ctrl, out_data});
            end else check("out_word", {out_ctrl, out_data}, exp_words.pop_front());
        end
        if (pkt_removed) begin
            if (exp_rm.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pkt_removed: got oq %0d, expected none", src_oq);
            end else begin
                r = exp_rm.pop_front();
                check("removed_oq", 72'(src_oq), 72'(r.q));
                check("new_ptr", 72'(src_oq_rd_addr_new), 72'(r.ptr));
                q_rd[r.q] = r.ptr;
                q_cnt[r.q]--;
            end
        end
        if (af_prev && !ack_rand) check("req_while_af", 72'(rd_0_req), 72'(0));
        for (int i = 0; i < 5; i++) src_oq_empty[i] = (q_cnt[i] == 0);
        src_oq_rd_addr   = q_rd[src_oq];
        src_oq_low_addr  = q_lo[src_oq];
        src_oq_high_addr = q_hi[src_oq];
        rd_0_ack = rd_0_req && (!ack_rand || $urandom_range(0, 3) != 0);
        if (rd_0_ack) begin
            pend.push_back('{cyc + LAT, rd_0_addr});
            ack_cnt++;
        end
        rd_0_vld = 1'b0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            rd_0_vld  = 1'b1;
            rd_0_data = mem_word(p.a);
        end
        af_prev = out_almost_full;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(string name);
        int t = 0;
        while ((exp_rm.size() != 0 || exp_words.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        check({name, "_pkts_left"}, 72'(exp_rm.size()), 72'(0));
        check({name, "_words_left"}, 72'(exp_words.size()), 72'(0));
    endtask

    initial begin
        int t, a0, wrs, rms, reqs;
        vecs[0] = '{2, 19'h00100, 19'h00100, 19'h001FF, 8'd3, 19'h00104};
        vecs[1] = '{2, 19'h001FE, 19'h00100, 19'h001FF, 8'd3, 19'h00102};
        vecs[2] = '{4, 19'h00050, 19'h00000, 19'h000FF, 8'd0, 19'h00051};
        vecs[3] = '{4, 19'h001FF, 19'h00100, 19'h001FF, 8'd0, 19'h00100};
        vecs[4] = '{1, 19'h00010, 19'h00010, 19'h00013, 8'd5, 19'h00012};
        vecs[5] = '{0, 19'h7FFFE, 19'h7FF00, 19'h7FFFF, 8'd2, 19'h7FF01};
        for (int i = 0; i < 8; i++) begin
            q_cnt[i] = 0;
            set_q(i, 19'h0, 19'h0, 19'h0);
        end
        reset = 1'b1;
        out_almost_full = 1'b0;
        src_oq_empty = '1;
        src_oq_rd_addr = '0;
        src_oq_low_addr = '0;
        src_oq_high_addr = '0;
        rd_0_ack = 1'b0;
        rd_0_vld = 1'b0;
        rd_0_data = '0;
        repeat (3) tick();
        check("rst_rd_src_addr", 72'(rd_src_addr), 72'(0));
        check("rst_src_oq", 72'(src_oq), 72'(0));
        check("rst_rd_0_req", 72'(rd_0_req), 72'(0));
        check("rst_rd_0_addr", 72'(rd_0_addr), 72'(0));
        check("rst_pkt_removed", 72'(pkt_removed), 72'(0));
        check("rst_out_wr", 72'(out_wr), 72'(0));
        check("rst_new_ptr", 72'(src_oq_rd_addr_new), 72'(0));
        check("rst_out_word", {out_ctrl, out_data}, 72'(0));
        reset = 1'b0;
        repeat (3) tick();
        check("idle_no_request", 72'(rd_src_addr), 72'(0));

        for (int i = 0; i < 6; i++) begin
            set_q(vecs[i].q, vecs[i].rd, vecs[i].lo, vecs[i].hi);
            add_pkt(vecs[i].q, vecs[i].n, vecs[i].new_ptr);
            wait_done($sformatf("vec%0d", i));
        end

        ack_rand = 1'b0;
        set_q(2, 19'h00180, 19'h00100, 19'h001FF);
        add_pkt(2, 8'd8, 19'h00189);
        t = 0;
        while (exp_words.size() > 7 && t < 500) begin
            tick();
            t++;
        end
        check("stall_start_seen", 72'(exp_words.size() <= 7), 72'(1));
        out_almost_full = 1'b1;
        repeat (10) tick();
        out_almost_full = 1'b0;
        wait_done("stall");
        ack_rand = 1'b1;

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        set_q(0, 19'h00000, 19'h00000, 19'h000FF);
        set_q(1, 19'h00200, 19'h00200, 19'h002FF);
        set_q(3, 19'h00300, 19'h00300, 19'h003FF);
        add_pkt(0, 8'd2, 19'h00003);
        add_pkt(1, 8'd1, 19'h00202);
        add_pkt(3, 8'd0, 19'h00301);
        add_pkt(0, 8'd1, 19'h00005);
        wait_done("rr_order");

        ack_rand = 1'b0;
        set_q(1, 19'h00400, 19'h00400, 19'h004FF);
        a0 = ack_cnt;
        add_pkt(1, 8'd8, 19'h00409);
        t = 0;
        while (ack_cnt < a0 + 3 && t < 500) begin
            tick();
            t++;
        end
        check("abort_acks_seen", 72'(ack_cnt >= a0 + 3), 72'(1));
        reset = 1'b1;
        q_cnt[1] = 0;
        tick();
        exp_words.delete();
        exp_rm.delete();
        reset = 1'b0;
        wrs = 0;
        rms = 0;
        reqs = 0;
        repeat (12) begin
            tick();
            wrs += int'(out_wr);
            rms += int'(pkt_removed);
            reqs += int'(rd_0_req || rd_src_addr);
        end
        check("abort_out_wr", 72'(wrs), 72'(0));
        check("abort_pkt_removed", 72'(rms), 72'(0));
        check("abort_idle", 72'(reqs), 72'(0));
        check("abort_ptr_kept", 72'(q_rd[1]), 72'(19'h00400));
        set_q(1, 19'h00400, 19'h00400, 19'h004FF);
        add_pkt(1, 8'd1, 19'h00402);
        wait_done("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
